uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 32-bit UART transmitter between NUM_REQ requesters.
- Latches the granted requester's word and issues a one-cycle NewData pulse to the transmitter.
- Tracks the transmitter's DoneTx, including the time taken by internal parity-error retransmissions.
- Returns Ack to the requester on success, or Nack on timeout.
- Sits between the producer blocks and the transmitter, in the baud-clock domain.

---
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ requesters.
// Latches the granted word, pulses NewData, then waits for DoneTx (Ack) or a timeout (Nack).
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    CLK_Baudin,
  input  logic                    RstTx,
  input  logic [NUM_REQ-1:0]      Req,
  input  logic [NUM_REQ*SIZE-1:0] DataReq,
  output logic [NUM_REQ-1:0]      Ack,
  output logic [NUM_REQ-1:0]      Nack,
  output logic [NUM_REQ-1:0]      Grant,
  output logic [SIZE-1:0]         TxData,
  output logic                    TxNewData,
  input  logic                    TxDone,
  output logic                    Busy,
  output logic [7:0]              ErrCount
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_CLR  = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RELEASE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  nack_q, nack_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [SIZE-1:0]     txd_q, txd_d;
  logic                new_q, new_d;
  logic                busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          err_q, err_d;

  logic                sel_valid;
  logic [IW-1:0]       sel_idx;
  logic                timeout_hit;

  // Scanning offsets downward lets the smallest offset from the pointer overwrite the rest.
  always_comb begin
    int j;
    j         = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (Req[j]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(j);
      end
    end
  end

  assign timeout_hit = (cnt_q == CNT_LIMIT);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    txd_d   = txd_q;
    new_d   = 1'b0;
    busy_d  = busy_q;
    ack_d   = '0;
    nack_d  = '0;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          grant_d = NUM_REQ'(1) << sel_idx;
          idx_d   = sel_idx;
          txd_d   = DataReq[int'(sel_idx)*SIZE +: SIZE];
          new_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT_CLR;
        end
      end

      S_WAIT_CLR, S_WAIT_DONE: begin
        cnt_d = cnt_q + CW'(1);
        if ((state_q == S_WAIT_CLR) && !TxDone) begin
          state_d = S_WAIT_DONE;
        end else if ((state_q == S_WAIT_DONE) && TxDone) begin
          ack_d   = grant_q;
          state_d = S_RELEASE;
        end else if (timeout_hit) begin
          // Success is tested first, so a simultaneous DoneTx beats the timeout.
          nack_d  = grant_q;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        state_d = S_IDLE;
      end

      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK_Baudin or posedge RstTx) begin
    if (RstTx) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      txd_q   <= '0;
      new_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      nack_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      txd_q   <= txd_d;
      new_q   <= new_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign Ack       = ack_q;
  assign Nack      = nack_q;
  assign Grant     = grant_q;
  assign TxData    = txd_q;
  assign TxNewData = new_q;
  assign Busy      = busy_q;
  assign ErrCount  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table for one frame, then hand-written
// sequences for round-robin order, retransmission, timeout, async reset and held DoneTx.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int W       = 32;
  localparam int TMO     = 20;
  localparam int FRAME   = 5;

  localparam logic [W-1:0] WORD0 = 32'hA5A5_0F0F;
  localparam logic [W-1:0] WORD1 = 32'h1111_2222;
  localparam logic [W-1:0] WORD2 = 32'h3333_4444;
  localparam logic [W-1:0] WORD3 = 32'hDEAD_BEEF;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_req;
  logic [N-1:0]   ack, nack, grant;
  logic [W-1:0]   tx_data;
  logic           tx_new;
  logic           tx_done;
  logic           busy;
  logic [7:0]     err_count;

  logic           model_en;
  logic           model_done;
  logic           man_done;
  int             retx;
  int             rem;

  int vectors;
  int miscompares;
  int cyc;

  uart_tx_arbiter #(.NUM_REQ(N), .SIZE(W), .TIMEOUT(TMO)) dut (
    .CLK_Baudin (clk),
    .RstTx      (rst),
    .Req        (req),
    .DataReq    (data_req),
    .Ack        (ack),
    .Nack       (nack),
    .Grant      (grant),
    .TxData     (tx_data),
    .TxNewData  (tx_new),
    .TxDone     (tx_done),
    .Busy       (busy),
    .ErrCount   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_done = model_en ? model_done : man_done;

  // Transmitter model: DoneTx drops on NewData and rises after FRAME cycles per round.
  initial begin
    model_done = 1'b0;
    rem        = 0;
  end
  always @(negedge clk) begin
    if (rst) begin
      model_done = 1'b0;
      rem        = 0;
    end else if (tx_new) begin
      model_done = 1'b0;
      rem        = FRAME * (retx + 1);
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) model_done = 1'b1;
    end
  end

  typedef struct {
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] ack;
    logic [N-1:0] nack;
    logic [N-1:0] grant;
    logic         new_data;
    logic         busy;
    logic [W-1:0] txd;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0: TxNewData pulse, 1: any Ack, 2: any Nack
  task automatic wait_until(input int kind, input string name, output int at);
    bit hit;
    hit = 1'b0;
    at  = 0;
    for (int n = 0; n < 100 && !hit; n++) begin
      tick();
      case (kind)
        0:       hit = (tx_new === 1'b1);
        1:       hit = ((|ack) === 1'b1);
        default: hit = ((|nack) === 1'b1);
      endcase
    end
    if (hit) begin
      at = cyc;
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL %s: event not seen within 100 cycles", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g_at, a_at, n_at, new_cnt, ack_cnt, nack_cnt;
    logic [N-1:0] rr_exp [5];
    logic [N-1:0] ack_seen;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    req         = '0;
    data_req    = {WORD3, WORD2, WORD1, WORD0};
    model_en    = 1'b0;
    man_done    = 1'b0;
    retx        = 0;

    // {req, TxDone, Ack, Nack, Grant, TxNewData, Busy, TxData} after each edge
    tbl[0] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1, WORD0};
    tbl[1] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, WORD0};
    tbl[2] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, WORD0};
    tbl[3] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, WORD0};
    tbl[4] = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1, WORD0};
    tbl[5] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, WORD0};
    tbl[6] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, WORD0};

    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    check("reset grant", 32'(grant), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset newdata", 32'(tx_new), 32'h0);
    check("reset ack", 32'(ack), 32'h0);
    check("reset nack", 32'(nack), 32'h0);
    check("reset txdata", tx_data, 32'h0);
    check("reset errcount", 32'(err_count), 32'h0);

    // Single frame, cycle by cycle
    for (int i = 0; i < 7; i++) begin
      req      = tbl[i].req;
      man_done = tbl[i].done;
      tick();
      check($sformatf("v%0d ack", i), 32'(ack), 32'(tbl[i].ack));
      check($sformatf("v%0d nack", i), 32'(nack), 32'(tbl[i].nack));
      check($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].grant));
      check($sformatf("v%0d newdata", i), 32'(tx_new), 32'(tbl[i].new_data));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("v%0d txdata", i), tx_data, tbl[i].txd);
    end

    // Round robin with all requests held
    do_reset();
    model_en = 1'b1;
    req      = 4'b1111;
    a_at     = 0;
    for (int k = 0; k < 5; k++) begin
      wait_until(0, $sformatf("rr grant %0d", k), g_at);
      check($sformatf("rr grant %0d", k), 32'(grant), 32'(rr_exp[k]));
      if (k == 0) check("rr first data", tx_data, WORD0);
      if (k > 0) check($sformatf("rr ack-to-grant gap %0d", k), 32'(g_at - a_at), 32'd2);
      wait_until(1, $sformatf("rr ack %0d", k), a_at);
      check($sformatf("rr ack %0d", k), 32'(ack), 32'(rr_exp[k]));
    end
    req = '0;
    tick();
    tick();

    // One retransmit round: single Ack, single NewData, no Nack
    retx     = 1;
    req      = 4'b0010;
    new_cnt  = 0;
    ack_cnt  = 0;
    nack_cnt = 0;
    ack_seen = '0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (tx_new === 1'b1) new_cnt++;
      if ((|nack) === 1'b1) nack_cnt++;
      if ((|ack) === 1'b1) begin
        ack_cnt++;
        ack_seen = ack;
        req      = '0;
      end
    end
    check("retx ack count", 32'(ack_cnt), 32'd1);
    check("retx ack bit", 32'(ack_seen), 32'b0010);
    check("retx nack count", 32'(nack_cnt), 32'd0);
    check("retx newdata count", 32'(new_cnt), 32'd1);
    check("retx errcount", 32'(err_count), 32'd0);
    retx = 0;

    // Timeout with DoneTx stuck low
    do_reset();
    model_en = 1'b0;
    man_done = 1'b0;
    req      = 4'b0100;
    wait_until(0, "tmo grant", g_at);
    check("tmo grant", 32'(grant), 32'b0100);
    wait_until(2, "tmo nack", n_at);
    check("tmo nack latency", 32'(n_at - g_at), 32'(TMO));
    check("tmo nack bit", 32'(nack), 32'b0100);
    check("tmo ack quiet", 32'(ack), 32'h0);
    check("tmo errcount", 32'(err_count), 32'd1);
    tick();
    check("tmo grant cleared", 32'(grant), 32'h0);
    check("tmo busy cleared", 32'(busy), 32'h0);
    for (int t = 0; t < 253; t++) wait_until(2, "tmo repeat", n_at);
    check("tmo errcount 254", 32'(err_count), 32'd254);
    for (int t = 0; t < 6; t++) wait_until(2, "tmo saturate", n_at);
    check("tmo errcount saturated", 32'(err_count), 32'd255);
    req = '0;
    tick();
    tick();

    // Async reset in WAIT_DONE; pointer currently sits at 3
    model_en = 1'b1;
    req      = 4'b0100;
    wait_until(0, "rst grant", g_at);
    check("rst pre grant", 32'(grant), 32'b0100);
    tick();
    tick();
    tick();
    check("rst pre busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst async grant", 32'(grant), 32'h0);
    check("rst async busy", 32'(busy), 32'h0);
    check("rst async txdata", tx_data, 32'h0);
    check("rst async errcount", 32'(err_count), 32'h0);
    check("rst async ack", 32'(ack), 32'h0);
    check("rst async nack", 32'(nack), 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    model_en = 1'b0;
    man_done = 1'b0;
    req      = 4'b1010;
    wait_until(0, "rst next grant", g_at);
    check("rst pointer cleared", 32'(grant), 32'b0010);
    check("rst next data", tx_data, WORD1);

    // Finish requester 1, then grant 3 with DoneTx still high from that frame
    tick();
    man_done = 1'b1;
    tick();
    check("held ack1", 32'(ack), 32'b0010);
    req = 4'b1000;
    tick();
    tick();
    check("held grant3 newdata", 32'(tx_new), 32'd1);
    check("held grant3", 32'(grant), 32'b1000);
    for (int n = 0; n < 4; n++) begin
      tick();
      check($sformatf("held no early ack %0d", n), 32'(ack), 32'h0);
      check($sformatf("held busy %0d", n), 32'(busy), 32'd1);
      check($sformatf("held data %0d", n), tx_data, WORD3);
    end
    man_done = 1'b0;
    tick();
    tick();
    check("held still no ack", 32'(ack), 32'h0);
    man_done = 1'b1;
    tick();
    check("held ack3", 32'(ack), 32'b1000);
    req = '0;
    tick();
    tick();
    check("held idle busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
